// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the shared slow memory.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding caches and memory that drive the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              mem_read_I;
   logic              mem_write_I;
   logic [ADDR_W-1:0] mem_addr_I;
   logic [DATA_W-1:0] mem_wdata_I;
   logic [DATA_W-1:0] mem_rdata_I;
   logic              mem_ready_I;

   logic              mem_read_D;
   logic              mem_write_D;
   logic [ADDR_W-1:0] mem_addr_D;
   logic [DATA_W-1:0] mem_wdata_D;
   logic [DATA_W-1:0] mem_rdata_D;
   logic              mem_ready_D;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
      output mem_rdata_I, mem_ready_I,
      input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
      output mem_rdata_D, mem_ready_D,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
      input  mem_rdata_I, mem_ready_I,
      output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
      input  mem_rdata_D, mem_ready_D,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow memory port between the I-cache and
// the D-cache. A granted cache is connected straight through to the memory
// until mem_ready, then a one-cycle RELEASE lets it drop its request so the
// same request is never served twice.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_I   = 2'd1,
      GNT_D   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   state_t state;
   state_t next_state;
   logic   last_gnt;
   logic   pend_I;
   logic   pend_D;

   assign pend_I = bus.mem_read_I | bus.mem_write_I;
   assign pend_D = bus.mem_read_D | bus.mem_write_D;

   // Read data is broadcast to both caches; only the ready qualifies it.
   assign bus.mem_rdata_I = bus.mem_rdata;
   assign bus.mem_rdata_D = bus.mem_rdata;

   // State register; the round-robin bit records who was granted last.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_gnt <= LAST_I;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == GNT_I) begin
            last_gnt <= LAST_I;
         end else if (state == IDLE && next_state == GNT_D) begin
            last_gnt <= LAST_D;
         end
      end
   end

   // Next-state: arbitrate only in IDLE, hold a grant until ready or withdrawal.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (pend_I && pend_D) begin
               next_state = (last_gnt == LAST_I) ? GNT_D : GNT_I;
            end else if (pend_I) begin
               next_state = GNT_I;
            end else if (pend_D) begin
               next_state = GNT_D;
            end
         end
         GNT_I: begin
            if (bus.mem_ready) begin
               next_state = RELEASE;
            end else if (!pend_I) begin
               next_state = IDLE;
            end
         end
         GNT_D: begin
            if (bus.mem_ready) begin
               next_state = RELEASE;
            end else if (!pend_D) begin
               next_state = IDLE;
            end
         end
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs: route the granted cache to memory, quiet bus otherwise and in reset.
   always_comb begin
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_addr    = {ADDR_W{1'b0}};
      bus.mem_wdata   = {DATA_W{1'b0}};
      bus.mem_ready_I = 1'b0;
      bus.mem_ready_D = 1'b0;
      if (rst_n) begin
         case (state)
            GNT_I: begin
               bus.mem_read    = bus.mem_read_I;
               bus.mem_write   = bus.mem_write_I;
               bus.mem_addr    = bus.mem_addr_I;
               bus.mem_wdata   = bus.mem_wdata_I;
               bus.mem_ready_I = bus.mem_ready;
            end
            GNT_D: begin
               bus.mem_read    = bus.mem_read_D;
               bus.mem_write   = bus.mem_write_D;
               bus.mem_addr    = bus.mem_addr_D;
               bus.mem_wdata   = bus.mem_wdata_D;
               bus.mem_ready_D = bus.mem_ready;
            end
            default: begin
               bus.mem_read = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed cycle table, grant alternation sequence
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int BUS_W  = ADDR_W + DATA_W + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model: owner -1 none, 0 I-cache, 1 D-cache.
   int m_owner = -1;
   bit m_cool  = 1'b0;
   int m_last  = 0;

   typedef struct {
      logic r;
      logic ri;
      logic wi;
      logic rd;
      logic wd;
      logic rdy;
      int   gnt;
      logic e_rdy_i;
      logic e_rdy_d;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic ri, logic wi, logic rd, logic wd,
                               logic rdy, int gnt, logic ei, logic ed);
      vec_t v;
      v.r = r; v.ri = ri; v.wi = wi; v.rd = rd; v.wd = wd; v.rdy = rdy;
      v.gnt = gnt; v.e_rdy_i = ei; v.e_rdy_d = ed;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Shared bus contents expected when the given requester owns the port.
   function automatic logic [BUS_W-1:0] bus_for(int owner);
      if (owner == 0)
         return {bus.mem_read_I, bus.mem_write_I, bus.mem_addr_I, bus.mem_wdata_I};
      if (owner == 1)
         return {bus.mem_read_D, bus.mem_write_D, bus.mem_addr_D, bus.mem_wdata_D};
      return '0;
   endfunction

   function automatic logic [BUS_W-1:0] dut_bus();
      return {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata};
   endfunction

   task automatic applyStimulus(input logic r, input logic ri, input logic wi,
                                input logic rd, input logic wd, input logic rdy);
      rst_n           = r;
      bus.mem_read_I  = ri;
      bus.mem_write_I = wi;
      bus.mem_read_D  = rd;
      bus.mem_write_D = wd;
      bus.mem_ready   = rdy;
      bus.mem_rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
   endtask

   // Compare against the model, then advance one clock and update the model.
   task automatic stepCycle();
      int   own;
      bit   pend [2];
      int   pick;
      own = rst_n ? m_owner : -1;
      checkOutput("model_bus", 256'(dut_bus()), 256'(bus_for(own)));
      checkOutput("model_ready", 256'({bus.mem_ready_I, bus.mem_ready_D}),
                  256'({own == 0 && bus.mem_ready, own == 1 && bus.mem_ready}));
      checkOutput("rdata", 256'({bus.mem_rdata_I, bus.mem_rdata_D}),
                  256'({bus.mem_rdata, bus.mem_rdata}));
      @(posedge clk);
      pend[0] = bus.mem_read_I | bus.mem_write_I;
      pend[1] = bus.mem_read_D | bus.mem_write_D;
      if (!rst_n) begin
         m_owner = -1; m_cool = 1'b0; m_last = 0;
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else if (m_owner >= 0) begin
         if (bus.mem_ready) begin
            m_owner = -1; m_cool = 1'b1;
         end else if (!pend[m_owner]) begin
            m_owner = -1;
         end
      end else if (pend[0] || pend[1]) begin
         pick    = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
         m_owner = pick;
         m_last  = pick;
      end
      @(negedge clk);
   endtask

   initial begin
      int order [$];
      int wait_cnt;
      int cyc;

      bus.mem_addr_I  = 28'h0000010;
      bus.mem_wdata_I = 128'h0123456789ABCDEF_FEDCBA9876543210;
      bus.mem_addr_D  = 28'h1234567;
      bus.mem_wdata_D = {16{8'hA5}};
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // Single I read, ready four cycles after grant, then RELEASE and IDLE.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      // I withdraws during its grant: back to IDLE without retry.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      // Contention right after reset: D first, then I.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 1, 2, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      // Reset mid GNT_I, then contention grants D again.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 2, 0, 0));
      // D write, ready during D grant, spurious readies in RELEASE/IDLE.
      vecs.push_back(mk(1, 1, 0, 0, 1, 0, 2, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 1, 2, 0, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].r, vecs[i].ri, vecs[i].wi, vecs[i].rd,
                       vecs[i].wd, vecs[i].rdy);
         checkOutput($sformatf("vec%0d_bus", i), 256'(dut_bus()),
                     256'(bus_for(vecs[i].gnt - 1)));
         checkOutput($sformatf("vec%0d_ready", i),
                     256'({bus.mem_ready_I, bus.mem_ready_D}),
                     256'({vecs[i].e_rdy_i, vecs[i].e_rdy_d}));
         stepCycle();
      end

      // Both caches pending continuously: six completions must alternate D, I.
      wait_cnt = 0;
      cyc      = 0;
      while (order.size() < 6 && cyc < 200) begin
         applyStimulus(1, 1, 0, 1, 0, 0);
         if (bus.mem_read) begin
            if (wait_cnt == 2) begin
               bus.mem_ready = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         #1;
         if (bus.mem_ready_I) order.push_back(0);
         if (bus.mem_ready_D) order.push_back(1);
         stepCycle();
         cyc++;
      end
      checkOutput("alt_count", 256'(order.size()), 256'(6));
      for (int i = 0; i < 6; i++) begin
         if (i < order.size())
            checkOutput($sformatf("alt_grant%0d", i), 256'(order[i]),
                        256'((i % 2 == 0) ? 1 : 0));
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         bus.mem_addr_I  = ADDR_W'($urandom());
         bus.mem_addr_D  = ADDR_W'($urandom());
         bus.mem_wdata_I = {$urandom(), $urandom(), $urandom(), $urandom()};
         bus.mem_wdata_D = {$urandom(), $urandom(), $urandom(), $urandom()};
         applyStimulus($urandom_range(0, 39) != 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 3) == 0);
         stepCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
